// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// State enum, opcode/funct constants, mux select encodings and ALUOp codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RS     = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] M2R_MDR    = 2'd0;
    localparam logic [1:0] M2R_ALUOUT = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] SA_PC    = 2'd0;
    localparam logic [1:0] SA_RS    = 2'd1;
    localparam logic [1:0] SA_SHAMT = 2'd2;

    localparam logic [1:0] SB_RT     = 2'd0;
    localparam logic [1:0] SB_FOUR   = 2'd1;
    localparam logic [1:0] SB_IMM    = 2'd2;
    localparam logic [1:0] SB_IMM_SH = 2'd3;

    localparam logic [2:0] AOP_ADD    = 3'b000;
    localparam logic [2:0] AOP_BRANCH = 3'b001;
    localparam logic [2:0] AOP_RTYPE  = 3'b010;
    localparam logic [2:0] AOP_AND    = 3'b100;
    localparam logic [2:0] AOP_SLT    = 3'b101;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and memory ready in, enables/selects/counters out.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_controller_if
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [5:0]       OpCode;
    logic [5:0]       Funct;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       PCSource;
    logic             ir_write;
    logic             iord;
    logic             MemRead;
    logic             MemWrite;
    logic             RegWrite;
    logic [1:0]       RegDst;
    logic [1:0]       MemtoReg;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [3:0]       ALUOp;
    logic [2:0]       Branch;
    logic             ExtOp;
    logic             LuiOp;
    logic             illegal;
    state_e           state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  OpCode, Funct, mem_ready,
        output pc_write, pc_write_cond, PCSource, ir_write, iord, MemRead, MemWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, Branch, ExtOp,
               LuiOp, illegal, state, cycle_cnt, instr_cnt
    );

    modport slave (
        output OpCode, Funct, mem_ready,
        input  pc_write, pc_write_cond, PCSource, ir_write, iord, MemRead, MemWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, Branch, ExtOp,
               LuiOp, illegal, state, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/multicycle_controller_decode.sv
// Purely combinational opcode/funct classification feeding the controller FSM.
// Anything not listed here is an illegal encoding.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opCode,
    input  logic [5:0] funct,
    output logic       isRtype,
    output logic       isShift,
    output logic       isJump,
    output logic       isJumpReg,
    output logic       isLink,
    output logic       isBranch,
    output logic       isLoad,
    output logic       isStore,
    output logic       isImm,
    output logic       isAnd,
    output logic       isSlt,
    output logic       isLui,
    output logic       illegal
);
    always_comb begin
        isRtype   = 1'b0;
        isShift   = 1'b0;
        isJump    = 1'b0;
        isJumpReg = 1'b0;
        isLink    = 1'b0;
        isBranch  = 1'b0;
        isLoad    = 1'b0;
        isStore   = 1'b0;
        isImm     = 1'b0;
        isAnd     = 1'b0;
        isSlt     = 1'b0;
        isLui     = 1'b0;
        illegal   = 1'b0;
        case (opCode)
            OP_RTYPE: begin
                case (funct)
                    F_SLL, F_SRL, F_SRA: begin
                        isRtype = 1'b1;
                        isShift = 1'b1;
                    end
                    F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
                    F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: isRtype = 1'b1;
                    F_JR: begin
                        isJump    = 1'b1;
                        isJumpReg = 1'b1;
                    end
                    F_JALR: begin
                        isJump    = 1'b1;
                        isJumpReg = 1'b1;
                        isLink    = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_J:   isJump = 1'b1;
            OP_JAL: begin
                isJump = 1'b1;
                isLink = 1'b1;
            end
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: isBranch = 1'b1;
            OP_ADDI, OP_ADDIU: isImm = 1'b1;
            OP_ANDI: begin
                isImm = 1'b1;
                isAnd = 1'b1;
            end
            OP_SLTI, OP_SLTIU: begin
                isImm = 1'b1;
                isSlt = 1'b1;
            end
            OP_LUI: begin
                isImm = 1'b1;
                isLui = 1'b1;
            end
            OP_LW:   isLoad  = 1'b1;
            OP_SW:   isStore = 1'b1;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB, 2-5 cycles per instruction.
// Memory accesses stall in FETCH/MEM until mem_ready, holding strobes and address select.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter bit HANDSHAKE    = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_controller_if.master bus
);
    state_e           state, nextState;
    logic [CNT_W-1:0] cycleCnt, instrCnt;
    logic             retire, memOk;
    logic isRtype, isShift, isJump, isJumpReg, isLink, isBranch;
    logic isLoad, isStore, isImm, isAnd, isSlt, isLui, isIllegal;

    mc_decode uDecode (
        .opCode(bus.OpCode), .funct(bus.Funct),
        .isRtype(isRtype), .isShift(isShift), .isJump(isJump), .isJumpReg(isJumpReg),
        .isLink(isLink), .isBranch(isBranch), .isLoad(isLoad), .isStore(isStore),
        .isImm(isImm), .isAnd(isAnd), .isSlt(isSlt), .isLui(isLui), .illegal(isIllegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FETCH;
            cycleCnt <= '0;
            instrCnt <= '0;
        end else begin
            state <= nextState;
            if (state != ST_HALT) cycleCnt <= cycleCnt + CNT_W'(1);
            if (retire)           instrCnt <= instrCnt + CNT_W'(1);
        end
    end

    always_comb begin
        memOk             = HANDSHAKE ? bus.mem_ready : 1'b1;
        nextState         = state;
        retire            = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.PCSource      = PCS_ALU;
        bus.ir_write      = 1'b0;
        bus.iord          = 1'b0;
        bus.MemRead       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.RegDst        = RD_RT;
        bus.MemtoReg      = M2R_MDR;
        bus.ALUSrcA       = SA_PC;
        bus.ALUSrcB       = SB_RT;
        bus.ALUOp         = {1'b0, AOP_ADD};
        bus.Branch        = 3'b000;
        bus.illegal       = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = SB_FOUR;
                if (memOk) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    nextState    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                bus.ALUSrcB = SB_IMM_SH;
                if (isIllegal) begin
                    // Illegal instructions are dropped without counting as retired.
                    bus.illegal = 1'b1;
                    nextState   = ILLEGAL_TRAP ? ST_HALT : ST_FETCH;
                end else if (isJump) begin
                    bus.pc_write = 1'b1;
                    bus.PCSource = isJumpReg ? PCS_RS : PCS_JUMP;
                    if (isLink) begin
                        bus.RegWrite = 1'b1;
                        bus.RegDst   = isJumpReg ? RD_RD : RD_RA;
                        bus.MemtoReg = M2R_PC;
                    end
                    nextState = ST_FETCH;
                    retire    = 1'b1;
                end else begin
                    nextState = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (isRtype) begin
                    bus.ALUSrcA = isShift ? SA_SHAMT : SA_RS;
                    bus.ALUOp   = {bus.OpCode[0], AOP_RTYPE};
                    nextState   = ST_WB;
                end else if (isImm) begin
                    bus.ALUSrcA = SA_RS;
                    bus.ALUSrcB = SB_IMM;
                    bus.ALUOp   = {bus.OpCode[0], isAnd ? AOP_AND : (isSlt ? AOP_SLT : AOP_ADD)};
                    nextState   = ST_WB;
                end else if (isLoad || isStore) begin
                    bus.ALUSrcA = SA_RS;
                    bus.ALUSrcB = SB_IMM;
                    bus.ALUOp   = {bus.OpCode[0], AOP_ADD};
                    nextState   = ST_MEM;
                end else if (isBranch) begin
                    bus.ALUSrcA       = SA_RS;
                    bus.ALUOp         = {bus.OpCode[0], AOP_BRANCH};
                    bus.pc_write_cond = 1'b1;
                    bus.PCSource      = PCS_ALUOUT;
                    bus.Branch        = bus.OpCode[2:0];
                    nextState         = ST_FETCH;
                    retire            = 1'b1;
                end else begin
                    nextState = ST_FETCH;
                end
            end
            ST_MEM: begin
                bus.iord     = 1'b1;
                bus.MemRead  = isLoad;
                bus.MemWrite = isStore;
                if (memOk) begin
                    nextState = isLoad ? ST_WB : ST_FETCH;
                    retire    = !isLoad;
                end
            end
            ST_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = isLoad ? M2R_MDR : M2R_ALUOUT;
                bus.RegDst   = isRtype ? RD_RD : RD_RT;
                nextState    = ST_FETCH;
                retire       = 1'b1;
            end
            ST_HALT: nextState = ST_HALT;
            default: nextState = ST_FETCH;
        endcase
        bus.ExtOp = !isShift;
        bus.LuiOp = isLui;
        // Reset holds state in FETCH; only the ready-dependent and decode-driven outputs need gating.
        if (reset) begin
            bus.pc_write = 1'b0;
            bus.ir_write = 1'b0;
            bus.ExtOp    = 1'b0;
            bus.LuiOp    = 1'b0;
        end
    end

    assign bus.state     = state;
    assign bus.cycle_cnt = cycleCnt;
    assign bus.instr_cnt = instrCnt;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded bench for multicycle_controller: expected per-cycle states are queued
// with the stimulus and compared as the FSM advances; feature checks are inline per task.
module tb_multicycle_controller;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opCode, funct;
    logic       memReady;
    int         errors = 0;
    int         checks = 0;
    state_e      expQ[$];
    logic [11:0] opQ[$];

    multicycle_controller_if #(.CNT_W(32)) bus0 ();
    multicycle_controller_if #(.CNT_W(32)) bus1 ();

    assign bus0.OpCode = opCode;
    assign bus0.Funct = funct;
    assign bus0.mem_ready = memReady;
    assign bus1.OpCode = opCode;
    assign bus1.Funct = funct;
    assign bus1.mem_ready = memReady;

    multicycle_controller #(.CNT_W(32), .HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    multicycle_controller #(.CNT_W(32), .HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        memReady = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: expected state sequence per instruction class, zero wait.
    task automatic pushInstr(input logic [5:0] op, input logic [5:0] fn);
        int n;
        expQ.push_back(ST_FETCH);
        expQ.push_back(ST_DECODE);
        n = 2;
        if (!(op == OP_J || op == OP_JAL || (op == OP_RTYPE && (fn == F_JR || fn == F_JALR)))) begin
            expQ.push_back(ST_EXEC);
            n++;
            if (op == OP_LW) begin
                expQ.push_back(ST_MEM);
                expQ.push_back(ST_WB);
                n += 2;
            end else if (op == OP_SW) begin
                expQ.push_back(ST_MEM);
                n++;
            end else if (!(op == OP_REGIMM || (op >= OP_BEQ && op <= OP_BGTZ))) begin
                expQ.push_back(ST_WB);
                n++;
            end
        end
        repeat (n) opQ.push_back({op, fn});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        memReady = 1'b1;
        opCode = OP_RTYPE;
        funct = F_ADD;
        @(negedge clk);
        step();
        #1;
        checks++;
        if (bus0.state !== ST_FETCH) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", bus0.state);
        end
        checks++;
        if ({bus0.cycle_cnt, bus0.instr_cnt} !== 64'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus0.cycle_cnt, bus0.instr_cnt);
        end
        checks++;
        if ({bus0.MemRead, bus0.ALUSrcB} !== 3'b101) begin
            errors++; $display("FAIL reset_fetch_outs: got MemRead=%0d ALUSrcB=%0d expected 1/1", bus0.MemRead, bus0.ALUSrcB);
        end
        checks++;
        if ({bus0.pc_write, bus0.ir_write, bus0.iord, bus0.MemWrite, bus0.RegWrite, bus0.ExtOp,
             bus0.LuiOp, bus0.illegal, bus0.pc_write_cond, bus0.ALUSrcA, bus0.ALUOp} !== 15'd0) begin
            errors++; $display("FAIL reset_zero_outs: pc_write=%0d ir_write=%0d ExtOp=%0d expected all 0",
                               bus0.pc_write, bus0.ir_write, bus0.ExtOp);
        end
    endtask

    task automatic test_rtype();
        logic [0:4] mr = 5'b11111;
        state_e exp;
        applyReset();
        opCode = OP_RTYPE;
        funct = F_ADD;
        expQ = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH};
        for (int i = 0; i < 5; i++) begin
            memReady = mr[i];
            #1;
            exp = expQ.pop_front();
            checks++;
            if (bus0.state !== exp) begin
                errors++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, bus0.state, exp);
            end
            if (i == 0) begin
                checks++;
                if ({bus0.pc_write, bus0.ir_write, bus0.PCSource} !== 4'b1100) begin
                    errors++; $display("FAIL add_fetch: got pc_write=%0d ir_write=%0d PCSource=%0d expected 1/1/0",
                                       bus0.pc_write, bus0.ir_write, bus0.PCSource);
                end
            end
            if (exp == ST_EXEC) begin
                checks++;
                if ({bus0.ALUSrcA, bus0.ALUSrcB, bus0.ALUOp} !== 8'b01_00_0010) begin
                    errors++; $display("FAIL add_exec: got ALUSrcA=%0d ALUSrcB=%0d ALUOp=%b expected 1/0/0010",
                                       bus0.ALUSrcA, bus0.ALUSrcB, bus0.ALUOp);
                end
            end
            if (exp == ST_WB) begin
                checks++;
                if ({bus0.RegWrite, bus0.RegDst, bus0.MemtoReg, bus0.instr_cnt} !== {5'b1_01_01, 32'd0}) begin
                    errors++; $display("FAIL add_wb: got RegWrite=%0d RegDst=%0d MemtoReg=%0d instr=%0d expected 1/1/1/0",
                                       bus0.RegWrite, bus0.RegDst, bus0.MemtoReg, bus0.instr_cnt);
                end
            end
            if (i < 4) step();
        end
        checks++;
        if ({bus0.cycle_cnt, bus0.instr_cnt} !== {32'd4, 32'd1}) begin
            errors++; $display("FAIL add_counts: got cycle=%0d instr=%0d expected 4/1", bus0.cycle_cnt, bus0.instr_cnt);
        end
    endtask

    task automatic test_load_stall();
        logic [0:7] mr = 8'b11100111;
        state_e exp;
        applyReset();
        opCode = OP_LW;
        funct = 6'h00;
        expQ = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MEM, ST_MEM, ST_WB, ST_FETCH};
        for (int i = 0; i < 8; i++) begin
            memReady = mr[i];
            #1;
            exp = expQ.pop_front();
            checks++;
            if (bus0.state !== exp) begin
                errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus0.state, exp);
            end
            if (exp == ST_EXEC) begin
                checks++;
                if ({bus0.ALUSrcB, bus0.ALUOp} !== 6'b10_1000) begin
                    errors++; $display("FAIL lw_exec: got ALUSrcB=%0d ALUOp=%b expected 2/1000", bus0.ALUSrcB, bus0.ALUOp);
                end
            end
            if (exp == ST_MEM) begin
                checks++;
                if ({bus0.MemRead, bus0.iord, bus0.MemWrite} !== 3'b110) begin
                    errors++; $display("FAIL lw_mem[%0d]: got MemRead=%0d iord=%0d MemWrite=%0d expected 1/1/0",
                                       i, bus0.MemRead, bus0.iord, bus0.MemWrite);
                end
            end
            if (exp == ST_WB) begin
                checks++;
                if ({bus0.RegWrite, bus0.MemtoReg, bus0.RegDst} !== 5'b1_00_00) begin
                    errors++; $display("FAIL lw_wb: got RegWrite=%0d MemtoReg=%0d RegDst=%0d expected 1/0/0",
                                       bus0.RegWrite, bus0.MemtoReg, bus0.RegDst);
                end
            end
            if (i < 7) step();
        end
        checks++;
        if ({bus0.cycle_cnt, bus0.instr_cnt} !== {32'd7, 32'd1}) begin
            errors++; $display("FAIL lw_counts: got cycle=%0d instr=%0d expected 7/1", bus0.cycle_cnt, bus0.instr_cnt);
        end
    endtask

    task automatic test_store_stall();
        logic [0:6] mr = 7'b0111011;
        state_e exp;
        applyReset();
        opCode = OP_SW;
        funct = 6'h00;
        expQ = '{ST_FETCH, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MEM, ST_FETCH};
        for (int i = 0; i < 7; i++) begin
            memReady = mr[i];
            #1;
            exp = expQ.pop_front();
            checks++;
            if (bus0.state !== exp) begin
                errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, bus0.state, exp);
            end
            if (i == 0) begin
                checks++;
                if ({bus0.pc_write, bus0.ir_write, bus0.MemRead, bus0.iord} !== 4'b0010) begin
                    errors++; $display("FAIL sw_fetch_stall: got pc_write=%0d ir_write=%0d MemRead=%0d iord=%0d expected 0/0/1/0",
                                       bus0.pc_write, bus0.ir_write, bus0.MemRead, bus0.iord);
                end
            end
            if (exp == ST_MEM) begin
                checks++;
                if ({bus0.MemWrite, bus0.MemRead, bus0.iord, bus0.RegWrite} !== 4'b1010) begin
                    errors++; $display("FAIL sw_mem[%0d]: got MemWrite=%0d MemRead=%0d iord=%0d expected 1/0/1",
                                       i, bus0.MemWrite, bus0.MemRead, bus0.iord);
                end
            end
            if (i < 6) step();
        end
        checks++;
        if ({bus0.cycle_cnt, bus0.instr_cnt} !== {32'd6, 32'd1}) begin
            errors++; $display("FAIL sw_counts: got cycle=%0d instr=%0d expected 6/1", bus0.cycle_cnt, bus0.instr_cnt);
        end
    endtask

    task automatic test_branch();
        state_e exp;
        applyReset();
        opCode = OP_BEQ;
        funct = 6'h00;
        expQ = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_FETCH};
        for (int i = 0; i < 4; i++) begin
            #1;
            exp = expQ.pop_front();
            checks++;
            if (bus0.state !== exp) begin
                errors++; $display("FAIL beq_state[%0d]: got %0d expected %0d", i, bus0.state, exp);
            end
            if (exp == ST_EXEC) begin
                checks++;
                if ({bus0.pc_write_cond, bus0.pc_write, bus0.Branch, bus0.ALUOp, bus0.PCSource} !== 11'b1_0_100_0001_01) begin
                    errors++; $display("FAIL beq_exec: got pc_write_cond=%0d Branch=%b ALUOp=%b PCSource=%0d expected 1/100/0001/1",
                                       bus0.pc_write_cond, bus0.Branch, bus0.ALUOp, bus0.PCSource);
                end
            end
            if (i < 3) step();
        end
        checks++;
        if ({bus0.cycle_cnt, bus0.instr_cnt} !== {32'd3, 32'd1}) begin
            errors++; $display("FAIL beq_counts: got cycle=%0d instr=%0d expected 3/1", bus0.cycle_cnt, bus0.instr_cnt);
        end
    endtask

    task automatic test_jump();
        state_e exp;
        applyReset();
        opCode = OP_JAL;
        funct = 6'h00;
        expQ = '{ST_FETCH, ST_DECODE, ST_FETCH};
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = expQ.pop_front();
            checks++;
            if (bus0.state !== exp) begin
                errors++; $display("FAIL jal_state[%0d]: got %0d expected %0d", i, bus0.state, exp);
            end
            if (exp == ST_DECODE) begin
                checks++;
                if ({bus0.pc_write, bus0.PCSource, bus0.RegWrite, bus0.RegDst, bus0.MemtoReg} !== 8'b1_10_1_10_10) begin
                    errors++; $display("FAIL jal_decode: got pc_write=%0d PCSource=%0d RegWrite=%0d RegDst=%0d MemtoReg=%0d expected 1/2/1/2/2",
                                       bus0.pc_write, bus0.PCSource, bus0.RegWrite, bus0.RegDst, bus0.MemtoReg);
                end
            end
            if (i < 2) step();
        end
        checks++;
        if ({bus0.cycle_cnt, bus0.instr_cnt} !== {32'd2, 32'd1}) begin
            errors++; $display("FAIL jal_counts: got cycle=%0d instr=%0d expected 2/1", bus0.cycle_cnt, bus0.instr_cnt);
        end
    endtask

    task automatic test_illegal();
        applyReset();
        opCode = 6'h3f;
        funct = 6'h00;
        #1;
        step();
        #1;
        checks++;
        if ({bus0.state, bus0.illegal, bus1.illegal} !== {ST_DECODE, 2'b11}) begin
            errors++; $display("FAIL ill_decode: got state=%0d illegal=%0d/%0d expected 1/1/1",
                               bus0.state, bus0.illegal, bus1.illegal);
        end
        step();
        #1;
        checks++;
        if ({bus0.state, bus0.illegal, bus0.instr_cnt} !== {ST_FETCH, 1'b0, 32'd0}) begin
            errors++; $display("FAIL ill_notrap: got state=%0d illegal=%0d instr=%0d expected 0/0/0",
                               bus0.state, bus0.illegal, bus0.instr_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus1.state, bus1.cycle_cnt, bus1.MemRead, bus1.illegal} !== {ST_HALT, 32'd2, 2'b00}) begin
                errors++; $display("FAIL ill_halt[%0d]: got state=%0d cycle=%0d MemRead=%0d expected 5/2/0",
                                   i, bus1.state, bus1.cycle_cnt, bus1.MemRead);
            end
            step();
            #1;
        end
        applyReset();
        opCode = OP_RTYPE;
        funct = 6'h3f;
        #1;
        step();
        #1;
        checks++;
        if ({bus0.illegal, bus0.RegWrite} !== 2'b10) begin
            errors++; $display("FAIL ill_funct: got illegal=%0d RegWrite=%0d expected 1/0", bus0.illegal, bus0.RegWrite);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [0:3] mr = 4'b1110;
        applyReset();
        opCode = OP_SW;
        funct = 6'h00;
        for (int i = 0; i < 4; i++) begin
            memReady = mr[i];
            #1;
            if (i < 3) step();
        end
        checks++;
        if ({bus0.state, bus0.MemWrite} !== {ST_MEM, 1'b1}) begin
            errors++; $display("FAIL rst_mid_pre: got state=%0d MemWrite=%0d expected 3/1", bus0.state, bus0.MemWrite);
        end
        reset = 1'b1;
        memReady = 1'b1;
        #1;
        checks++;
        if ({bus0.state, bus0.MemWrite, bus0.pc_write, bus0.iord} !== {ST_FETCH, 3'b000}) begin
            errors++; $display("FAIL rst_mid_outs: got state=%0d MemWrite=%0d pc_write=%0d iord=%0d expected 0/0/0/0",
                               bus0.state, bus0.MemWrite, bus0.pc_write, bus0.iord);
        end
        checks++;
        if ({bus0.cycle_cnt, bus0.instr_cnt} !== 64'd0) begin
            errors++; $display("FAIL rst_mid_counts: got %0d/%0d expected 0/0", bus0.cycle_cnt, bus0.instr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] cur;
        state_e exp;
        int total;
        applyReset();
        expQ.delete();
        opQ.delete();
        pushInstr(OP_RTYPE, F_ADD);
        pushInstr(OP_LW, 6'h00);
        pushInstr(OP_SW, 6'h00);
        pushInstr(OP_BEQ, 6'h00);
        pushInstr(OP_J, 6'h00);
        pushInstr(OP_RTYPE, F_JR);
        pushInstr(OP_RTYPE, F_SLL);
        pushInstr(OP_ADDIU, 6'h00);
        pushInstr(OP_LUI, 6'h00);
        pushInstr(OP_RTYPE, F_JALR);
        pushInstr(OP_REGIMM, 6'h00);
        pushInstr(OP_SLTI, 6'h00);
        expQ.push_back(ST_FETCH);
        opQ.push_back({OP_RTYPE, F_ADD});
        total = expQ.size();
        for (int i = 0; i < total; i++) begin
            cur = opQ.pop_front();
            {opCode, funct} = cur;
            #1;
            exp = expQ.pop_front();
            checks++;
            if (bus0.state !== exp) begin
                errors++; $display("FAIL b2b_state[%0d]: got %0d expected %0d (op %h)", i, bus0.state, exp, cur[11:6]);
            end
            if (cur == {OP_RTYPE, F_SLL} && exp == ST_EXEC) begin
                checks++;
                if ({bus0.ALUSrcA, bus0.ExtOp} !== 3'b10_0) begin
                    errors++; $display("FAIL b2b_sll: got ALUSrcA=%0d ExtOp=%0d expected 2/0", bus0.ALUSrcA, bus0.ExtOp);
                end
            end
            if (cur[11:6] == OP_LUI && exp == ST_WB) begin
                checks++;
                if ({bus0.LuiOp, bus0.RegWrite, bus0.RegDst, bus0.MemtoReg} !== 6'b1_1_00_01) begin
                    errors++; $display("FAIL b2b_lui: got LuiOp=%0d RegDst=%0d MemtoReg=%0d expected 1/0/1",
                                       bus0.LuiOp, bus0.RegDst, bus0.MemtoReg);
                end
            end
            if (cur[11:6] == OP_SLTI && exp == ST_EXEC) begin
                checks++;
                if (bus0.ALUOp !== 4'b0101) begin
                    errors++; $display("FAIL b2b_slti: got ALUOp=%b expected 0101", bus0.ALUOp);
                end
            end
            if (i < total - 1) step();
        end
        checks++;
        if ({bus0.cycle_cnt, bus0.instr_cnt} !== {32'(total - 1), 32'd12}) begin
            errors++; $display("FAIL b2b_counts: got cycle=%0d instr=%0d expected %0d/12",
                               bus0.cycle_cnt, bus0.instr_cnt, total - 1);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_stall();
        test_store_stall();
        test_branch();
        test_jump();
        test_illegal();
        test_reset_mid_access();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
